// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: register/forward widths,
// forward-select codes, mul/div sequencer states and the register-compare helper.
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int FWD_W = 2;
  localparam int CNT_W = 6;

  localparam logic [FWD_W-1:0] FWD_REG = 2'b00,
                               FWD_WB  = 2'b01,
                               FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register numbers and enables in,
// stall/flush/forward controls and mul/div status out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] rsD, rtD, rsE, rtE;
  logic [REG_W-1:0] writeRegE, writeRegM, writeRegW;
  logic             Regfile_weE, Regfile_weM, Regfile_weW;
  logic             memToRegE, memToRegM;
  logic             branchD, pcSrcD;
  logic             mdStartE, mdOpE, mdUseD;

  logic             stallF, stallD, flushD, flushE;
  logic [FWD_W-1:0] forwardAE, forwardBE;
  logic             forwardAD, forwardBD;
  logic             mdBusy, mdDone;

  modport master (
    output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
           Regfile_weE, Regfile_weM, Regfile_weW, memToRegE, memToRegM,
           branchD, pcSrcD, mdStartE, mdOpE, mdUseD,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           forwardAD, forwardBD, mdBusy, mdDone
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
           Regfile_weE, Regfile_weM, Regfile_weW, memToRegE, memToRegM,
           branchD, pcSrcD, mdStartE, mdOpE, mdUseD,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           forwardAD, forwardBD, mdBusy, mdDone
  );
endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mul/div occupancy tracker: IDLE -> BUSY (cnt down to 0) -> DONE -> IDLE, with
// registered busy/done/last-busy flags.
module hazard_ctrl_md_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy,
  output logic done,
  output logic last_busy,
  output logic idle
);
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load_val;
  logic             busy_q, busy_d, done_q, done_d, last_q, last_d;

  always_comb begin
    load_val = op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        // A start in DONE goes straight back to BUSY without an IDLE bubble.
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = load_val;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = MD_IDLE;
    endcase
    busy_d = (state_d == MD_BUSY);
    done_d = (state_d == MD_DONE);
    last_d = busy_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign last_busy = last_q;
  assign idle      = ~busy_q & ~done_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use/branch/mul-div stalls, flushes
// and operand forwarding. Define HAZARD_FWD_EN to enable forwarding; otherwise
// forwards are tied off and any in-flight RAW on an ID source stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);
  logic             lw_stall, br_stall, md_stall, raw_stall, stall;
  logic [FWD_W-1:0] fwd_a_e, fwd_b_e;
  logic             fwd_a_d, fwd_b_d;
  logic             md_busy, md_done, md_last, md_idle;
  logic             hitE, hitM, hitW;

  hazard_ctrl_md_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md (
    .clk       (clk),
    .rst       (rst),
    .start     (hif.mdStartE),
    .op        (hif.mdOpE),
    .busy      (md_busy),
    .done      (md_done),
    .last_busy (md_last),
    .idle      (md_idle)
  );

  always_comb begin
    hitE = reg_match(hif.writeRegE, hif.rsD) | reg_match(hif.writeRegE, hif.rtD);
    hitM = reg_match(hif.writeRegM, hif.rsD) | reg_match(hif.writeRegM, hif.rtD);
    hitW = reg_match(hif.writeRegW, hif.rsD) | reg_match(hif.writeRegW, hif.rtD);

    lw_stall = hif.memToRegE & hitE;
    br_stall = hif.branchD & ((hif.Regfile_weE & hitE) | (hif.memToRegM & hitM));
    // The final BUSY cycle releases the consumer so it reaches EX as the result lands.
    md_stall = hif.mdUseD & ~md_idle & ~md_last;

`ifdef HAZARD_FWD_EN
    raw_stall = 1'b0;
    fwd_a_e = (hif.Regfile_weM & reg_match(hif.writeRegM, hif.rsE)) ? FWD_MEM :
              (hif.Regfile_weW & reg_match(hif.writeRegW, hif.rsE)) ? FWD_WB  : FWD_REG;
    fwd_b_e = (hif.Regfile_weM & reg_match(hif.writeRegM, hif.rtE)) ? FWD_MEM :
              (hif.Regfile_weW & reg_match(hif.writeRegW, hif.rtE)) ? FWD_WB  : FWD_REG;
    fwd_a_d = hif.Regfile_weM & ~hif.memToRegM & reg_match(hif.writeRegM, hif.rsD);
    fwd_b_d = hif.Regfile_weM & ~hif.memToRegM & reg_match(hif.writeRegM, hif.rtD);
`else
    raw_stall = (hif.Regfile_weE & hitE) | (hif.Regfile_weM & hitM) | (hif.Regfile_weW & hitW);
    fwd_a_e   = FWD_REG;
    fwd_b_e   = FWD_REG;
    fwd_a_d   = 1'b0;
    fwd_b_d   = 1'b0;
`endif
    stall = lw_stall | br_stall | md_stall | raw_stall;
  end

`ifndef HAZARD_FWD_EN
  logic unused_ex_srcs;
  assign unused_ex_srcs = ^{hif.rsE, hif.rtE};
`endif

  // Every output is forced low while reset is asserted, including the registered ones.
  assign hif.stallF    = stall & ~rst;
  assign hif.stallD    = stall & ~rst;
  assign hif.flushE    = stall & ~rst;
  assign hif.flushD    = hif.pcSrcD & ~stall & ~rst;
  assign hif.forwardAE = rst ? FWD_REG : fwd_a_e;
  assign hif.forwardBE = rst ? FWD_REG : fwd_b_e;
  assign hif.forwardAD = fwd_a_d & ~rst;
  assign hif.forwardBD = fwd_b_d & ~rst;
  assign hif.mdBusy    = md_busy & ~rst;
  assign hif.mdDone    = md_done & ~rst;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized check of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Reference mul/div occupancy: busy cycles still to run, and a done-this-cycle flag.
  int busy_left = 0;
  bit done_m    = 0;

  logic obs_busy, obs_done, obs_stall;

  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  function automatic bit m(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit         e_lw, e_br, e_md, e_raw, e_stall, e_fd, e_fad, e_fbd, busy, last, idle;
    logic [1:0] e_fa, e_fb;
    busy = busy_left > 0;
    last = busy_left == 1;
    idle = !busy && !done_m;
    e_lw = hif.memToRegE && (m(hif.writeRegE, hif.rsD) || m(hif.writeRegE, hif.rtD));
    e_br = hif.branchD &&
           ((hif.Regfile_weE && (m(hif.writeRegE, hif.rsD) || m(hif.writeRegE, hif.rtD))) ||
            (hif.memToRegM && (m(hif.writeRegM, hif.rsD) || m(hif.writeRegM, hif.rtD))));
    e_md = hif.mdUseD && !idle && !last;
`ifdef HAZARD_FWD_EN
    e_raw = 0;
    e_fa  = (hif.Regfile_weM && m(hif.writeRegM, hif.rsE)) ? 2'd2 :
            (hif.Regfile_weW && m(hif.writeRegW, hif.rsE)) ? 2'd1 : 2'd0;
    e_fb  = (hif.Regfile_weM && m(hif.writeRegM, hif.rtE)) ? 2'd2 :
            (hif.Regfile_weW && m(hif.writeRegW, hif.rtE)) ? 2'd1 : 2'd0;
    e_fad = hif.Regfile_weM && !hif.memToRegM && m(hif.writeRegM, hif.rsD);
    e_fbd = hif.Regfile_weM && !hif.memToRegM && m(hif.writeRegM, hif.rtD);
`else
    e_raw = 0;
    for (int s = 0; s < 3; s++) begin
      logic [4:0] wr;
      bit         we;
      wr = (s == 0) ? hif.writeRegE : (s == 1) ? hif.writeRegM : hif.writeRegW;
      we = (s == 0) ? hif.Regfile_weE : (s == 1) ? hif.Regfile_weM : hif.Regfile_weW;
      if (we && (m(wr, hif.rsD) || m(wr, hif.rtD))) e_raw = 1;
    end
    e_fa = 2'd0; e_fb = 2'd0; e_fad = 0; e_fbd = 0;
`endif
    e_stall = e_lw || e_br || e_md || e_raw;
    e_fd    = hif.pcSrcD && !e_stall;
    if (rst) begin
      e_stall = 0; e_fd = 0; e_fa = 0; e_fb = 0; e_fad = 0; e_fbd = 0; busy = 0; done_m = done_m;
    end
    chk("stallF",    8'(hif.stallF),    8'(e_stall));
    chk("stallD",    8'(hif.stallD),    8'(e_stall));
    chk("flushE",    8'(hif.flushE),    8'(e_stall));
    chk("flushD",    8'(hif.flushD),    8'(e_fd));
    chk("forwardAE", 8'(hif.forwardAE), 8'(e_fa));
    chk("forwardBE", 8'(hif.forwardBE), 8'(e_fb));
    chk("forwardAD", 8'(hif.forwardAD), 8'(e_fad));
    chk("forwardBD", 8'(hif.forwardBD), 8'(e_fbd));
    chk("mdBusy",    8'(hif.mdBusy),    8'(busy));
    chk("mdDone",    8'(hif.mdDone),    8'(done_m && !rst));
    obs_busy  = hif.mdBusy;
    obs_done  = hif.mdDone;
    obs_stall = hif.stallF;
  endtask

  task automatic model_update();
    if (rst) begin
      busy_left = 0;
      done_m    = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) done_m = 1;
    end else begin
      done_m = 0;
      if (hif.mdStartE) busy_left = hif.mdOpE ? DIVC : MULC;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    assert (!(hif.mdStartE && busy_left > 0)) else begin
      fails++;
      $error("FAIL md_issue_in_busy observed=1 expected=0");
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
    hif.writeRegE = 0; hif.writeRegM = 0; hif.writeRegW = 0;
    hif.Regfile_weE = 0; hif.Regfile_weM = 0; hif.Regfile_weW = 0;
    hif.memToRegE = 0; hif.memToRegM = 0; hif.branchD = 0; hif.pcSrcD = 0;
    hif.mdStartE = 0; hif.mdOpE = 0; hif.mdUseD = 0;
  endtask

  initial begin
    int n_busy, n_stall, n_done;
    rst = 1'b1;
    clr();
    // Reset state with a hazard pattern on the inputs: everything must read 0.
    hif.memToRegE = 1; hif.writeRegE = 5; hif.rsD = 5; hif.pcSrcD = 1;
    step();
    step();
    rst = 1'b0;
    clr();
    step();

    // Load-use: lw $5 in EX, rsD = 5; then the lw sits in WB feeding rsE.
    hif.memToRegE = 1; hif.Regfile_weE = 1; hif.writeRegE = 5; hif.rsD = 5;
    step();
    chk("lw_stall", 8'(obs_stall), 8'd1);
    clr();
    hif.Regfile_weW = 1; hif.writeRegW = 5; hif.rsE = 5;
    step();

    // MEM wins over WB.
    clr();
    hif.Regfile_weM = 1; hif.writeRegM = 3; hif.Regfile_weW = 1; hif.writeRegW = 3;
    hif.rsE = 3; hif.rtE = 3;
    step();

    // Taken beq dependent on EX result, then the producer moves to MEM.
    clr();
    hif.branchD = 1; hif.pcSrcD = 1; hif.rtD = 7; hif.Regfile_weE = 1; hif.writeRegE = 7;
    step();
    chk("br_stall", 8'(obs_stall), 8'd1);
    hif.Regfile_weE = 0; hif.writeRegE = 0; hif.Regfile_weM = 1; hif.writeRegM = 7;
    step();

    // $0 writers everywhere never stall or forward.
    clr();
    hif.Regfile_weE = 1; hif.Regfile_weM = 1; hif.Regfile_weW = 1;
    hif.memToRegE = 1; hif.memToRegM = 1; hif.branchD = 1;
    step();
    chk("r0_stall", 8'(obs_stall), 8'd0);

    // div issue, mflo waiting in ID for the whole busy window.
    clr();
    hif.mdStartE = 1; hif.mdOpE = 1;
    step();
    hif.mdStartE = 0;
    n_busy = 0; n_stall = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      hif.mdUseD = (busy_left > 0);
      step();
      n_busy += int'(obs_busy);
      n_done += int'(obs_done);
      if (hif.mdUseD) n_stall += int'(obs_stall);
    end
    chk("div_busy_cycles",  8'(n_busy),  8'(DIVC));
    chk("div_stall_cycles", 8'(n_stall), 8'(DIVC - 1));
    chk("div_done_pulses",  8'(n_done),  8'd1);

    // Single mul and back-to-back issue from DONE.
    clr();
    hif.mdStartE = 1;
    step();
    hif.mdStartE = 0;
    for (int i = 0; i < MULC; i++) step();
    hif.mdStartE = 1;
    step();
    hif.mdStartE = 0;
    for (int i = 0; i < MULC + 3; i++) step();

    // Reset during BUSY at cnt = 10 aborts without a done pulse.
    clr();
    hif.mdStartE = 1; hif.mdOpE = 1;
    step();
    hif.mdStartE = 0; hif.mdUseD = 1;
    for (int i = 0; i < DIVC - 11; i++) step();
    rst = 1'b1;
    step();
    chk("rst_busy",  8'(obs_busy),  8'd0);
    chk("rst_stall", 8'(obs_stall), 8'd0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_done += int'(obs_done);
    end
    chk("rst_no_done", 8'(n_done), 8'd0);

    // Randomized traffic over a small register window to make matches common.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
      hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
      hif.writeRegE = 5'($urandom_range(0, 3));
      hif.writeRegM = 5'($urandom_range(0, 3));
      hif.writeRegW = 5'($urandom_range(0, 3));
      hif.Regfile_weE = 1'($urandom_range(0, 1));
      hif.Regfile_weM = 1'($urandom_range(0, 1));
      hif.Regfile_weW = 1'($urandom_range(0, 1));
      hif.memToRegE = 1'($urandom_range(0, 1));
      hif.memToRegM = 1'($urandom_range(0, 1));
      hif.branchD = 1'($urandom_range(0, 1));
      hif.pcSrcD = 1'($urandom_range(0, 1));
      hif.mdUseD = 1'($urandom_range(0, 1));
      hif.mdOpE = ($urandom_range(0, 3) == 0);
      hif.mdStartE = (busy_left == 0) && ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
